sd_clk_gen: RTL and testbench
=============================

# sd_clk_gen

Parametrised SD-card SPI clock generator: the successor to the fixed divide-by-2 SD clock in the SD top level. It derives `sd_ck` from the system clock with a programmable divider. It supports a slow identification mode (≤400 kHz) and a fast data mode, with glitch-free switching between them, and can run a clean-stop enable. It also runs an autonomous power-up wake burst (≥74 clocks with CS held high). It sits between the system clock and the SD command/data engines (`sd_initial` and successors), which consume its edge strobes.

## Interface
- `DIV_W`, 8: width of the half-period divider.
- `INIT_DIV`, 62: identification-mode half-period minus 1 (50 MHz → 397 kHz).
- `FAST_DIV`, 0: data-mode half-period minus 1 (50 MHz → 25 MHz).
- `WAKE_CYCLES`, 80: number of `sd_ck` periods in the wake burst; must be ≥74.
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: level; request `sd_ck` toggling.
- `fast_mode` input 1: level; 1 selects `FAST_DIV`, 0 selects `INIT_DIV`.
- `wake_req` input 1: single-cycle pulse; start the wake burst.
- `wake_busy` output 1: high while the wake burst runs.
- `wake_done` output 1: one-cycle pulse when the burst completes.
- `csn_hold` output 1: high during the wake burst; the top level ORs it into `SD_CSn`.
- `sd_ck` output 1: SD clock, registered; idle level low.
- `rise_stb` output 1: one-cycle pulse, high in the first `clk` cycle that `sd_ck` is 1.
- `fall_stb` output 1: one-cycle pulse, high in the first `clk` cycle that `sd_ck` is 0 after a high phase.
- `fast_active` output 1: divider currently in use is `FAST_DIV`.

## Operation
- The half-period counter `cnt` (`DIV_W` bits) runs while the clock is active.
  - When `cnt == div_act`: `sd_ck` toggles and `cnt` returns to 0.
  - Otherwise `cnt` increments.
- `div_act` is loaded from the `fast_mode` selection only at a falling-edge toggle (`sd_ck` 1→0) or while stopped. A mode change never shortens a high or low phase.
- Clock is active when `run` = 1 or `wake_busy` = 1.
- If `run` drops while `sd_ck` = 1, the high phase completes, `sd_ck` falls, then the clock stops. If `run` drops while `sd_ck` = 0, the clock stops immediately with `cnt` cleared.
- FSM states:
  - IDLE: `sd_ck` low, `cnt` 0.
  - RUN: normal toggling.
  - STOPPING: finishing the high phase.
  - WAKE: burst.
- Transitions:
  - IDLE → RUN on `run`.
  - RUN → STOPPING on `!run` with `sd_ck` = 1.
  - RUN → IDLE on `!run` with `sd_ck` = 0.
  - STOPPING → IDLE at the falling toggle.
  - IDLE → WAKE on `wake_req`.
  - WAKE → IDLE after the `WAKE_CYCLES`-th falling edge.
- Simultaneous `run` and `wake_req` in IDLE: WAKE wins. `run` is serviced after `wake_done`.
- WAKE behaviour:
  - Always uses `INIT_DIV`, ignoring `fast_mode`.
  - `csn_hold` = 1 and `wake_busy` = 1.
  - A period counter counts falling edges up to `WAKE_CYCLES`.
  - `wake_req` during WAKE, RUN or STOPPING is ignored (no queueing).
- `fast_active` reflects `div_act == FAST_DIV` and is registered with `div_act`.

## Timing
- Reset values (all outputs): `sd_ck` 0, `rise_stb` 0, `fall_stb` 0, `wake_busy` 0, `wake_done` 0, `csn_hold` 0, `fast_active` 0. Internal reset: `cnt` 0, `div_act` = `INIT_DIV`, state IDLE.
- `rst` mid-operation returns everything to the reset values on the next edge, including mid-wake. `wake_done` is not pulsed on reset.
- `sd_ck` period = 2·(`div_act`+1) `clk` cycles, 50 % duty. `FAST_DIV`=0 gives `clk`/2.
- First rising edge occurs `div_act`+1 cycles after `run` is sampled high in IDLE.
- `rise_stb` and `fall_stb` are registered in the same edge as the `sd_ck` toggle; they are never both high.
- `wake_busy` and `csn_hold` go high the cycle after `wake_req` and drop together with the `wake_done` pulse, one cycle after the last falling edge.
- `cnt` never exceeds `div_act`. Divider values wider than `DIV_W` are an elaboration error.

## Structure
- Shared package `sd_pkg` holds:
  - the FSM state enum `sd_clk_state_t` (IDLE, RUN, STOPPING, WAKE);
  - the default `INIT_DIV`/`FAST_DIV` for the 50 MHz system clock;
  - the SD-spec minimum `SD_WAKE_MIN` = 74.
- Single flat module. The wake period counter is inline and needs no sub-module.
- The top level instantiates `sd_clk_gen` in place of its toggle flop and drives `SD_CK` from `sd_ck`.

## Test plan
- Reset, then `run`=1, `fast_mode`=1 → `sd_ck` toggles every cycle; `rise_stb` on alternate cycles; `fast_active`=1.
- `run`=1, `fast_mode`=0 → high and low phases each 63 `clk` cycles; 1000 cycles produce 8 rising edges.
- Switch `fast_mode` 0→1 in mid high phase → that high phase stays 63 cycles; the following low phase is 1 cycle.
- Drop `run` 10 cycles into a high phase (slow mode) → `sd_ck` stays high 53 more cycles, falls with `fall_stb`, then stays low.
- `wake_req` pulse with `fast_mode`=1 → exactly 80 rising edges at slow rate, `csn_hold`=1 throughout, `wake_done` one cycle after the 80th fall; a `wake_req` issued mid-burst is ignored.
- Assert `rst` at wake edge 40 → next cycle all outputs 0 and no `wake_done`; a fresh `wake_req` gives a full 80-edge burst.

Source files
------------

// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD-card SPI front end.
//   sd_clk_state_t : state encoding of the SD clock generator
//   SD_INIT_DIV    : identification-mode half-period minus 1 at 50 MHz (~397 kHz)
//   SD_FAST_DIV    : data-mode half-period minus 1 at 50 MHz (25 MHz)
//   SD_WAKE_CYCLES : default length of the power-up wake burst in sd_ck periods
//   SD_WAKE_MIN    : minimum number of wake clocks the SD card requires
// ---------------------------------------------------------------------------
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2,
        WAKE     = 2'd3
    } sd_clk_state_t;

    localparam int SD_INIT_DIV    = 62;
    localparam int SD_FAST_DIV    = 0;
    localparam int SD_WAKE_CYCLES = 80;
    localparam int SD_WAKE_MIN    = 74;

endpackage : sd_pkg

// File: rtl/sd_clk_gen.sv
// ---------------------------------------------------------------------------
// sd_clk_gen
// Programmable SD-card SPI clock generator. Divides the system clock by
// 2*(div_act+1), with a slow identification divider and a fast data divider.
// Divider changes take effect only on a falling sd_ck edge (or while stopped),
// so no phase is ever shortened. Stopping always finishes a high phase, so
// sd_ck idles low. An autonomous wake burst emits WAKE_CYCLES slow clocks
// while holding chip select deasserted.
//
// Ports:
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   run         in  level, request sd_ck toggling
//   fast_mode   in  level, 1 = FAST_DIV, 0 = INIT_DIV
//   wake_req    in  pulse, start the wake burst (honoured only when idle)
//   wake_busy   out high while the wake burst runs
//   wake_done   out one-cycle pulse when the burst completes
//   csn_hold    out high during the burst, ORed into SD_CSn by the top level
//   sd_ck       out registered SD clock, idle low
//   rise_stb    out high in the first clk cycle with sd_ck = 1
//   fall_stb    out high in the first clk cycle with sd_ck = 0 after a high phase
//   fast_active out divider in use is FAST_DIV
// ---------------------------------------------------------------------------
module sd_clk_gen
    import sd_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int INIT_DIV    = SD_INIT_DIV,
    parameter int FAST_DIV    = SD_FAST_DIV,
    parameter int WAKE_CYCLES = SD_WAKE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic fast_mode,
    input  logic wake_req,
    output logic wake_busy,
    output logic wake_done,
    output logic csn_hold,
    output logic sd_ck,
    output logic rise_stb,
    output logic fall_stb,
    output logic fast_active
);

    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

    localparam logic [DIV_W-1:0]  INIT_V    = DIV_W'(INIT_DIV);
    localparam logic [DIV_W-1:0]  FAST_V    = DIV_W'(FAST_DIV);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES);

    // Reject dividers that would be silently truncated and bursts that are
    // too short for the card to wake up.
    if (INIT_DIV < 0 || INIT_DIV >= (1 << DIV_W)) begin : g_bad_init_div
        $error("sd_clk_gen: INIT_DIV does not fit in DIV_W bits");
    end
    if (FAST_DIV < 0 || FAST_DIV >= (1 << DIV_W)) begin : g_bad_fast_div
        $error("sd_clk_gen: FAST_DIV does not fit in DIV_W bits");
    end
    if (WAKE_CYCLES < SD_WAKE_MIN) begin : g_bad_wake
        $error("sd_clk_gen: WAKE_CYCLES below the SD wake minimum");
    end

    sd_clk_state_t     state, state_nx;
    logic [DIV_W-1:0]  cnt, cnt_nx;
    logic [DIV_W-1:0]  div_act, div_nx;
    logic [WAKE_W-1:0] wake_cnt, wake_cnt_nx;
    logic              ck_nx, rise_nx, fall_nx;
    logic              busy_nx, done_nx, csn_nx, fast_nx;
    logic              counting, load_div, wake_sel;

    // Next-state logic. Each state decides whether the half-period counter
    // advances this cycle; the shared counting section then handles toggles,
    // falling-edge divider reloads and the stop/wake exits tied to a fall.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        div_nx      = div_act;
        wake_cnt_nx = wake_cnt;
        ck_nx       = sd_ck;
        rise_nx     = 1'b0;
        fall_nx     = 1'b0;
        busy_nx     = wake_busy;
        done_nx     = 1'b0;
        csn_nx      = csn_hold;
        counting    = 1'b0;
        load_div    = 1'b0;
        wake_sel    = 1'b0;

        case (state)
            IDLE: begin
                cnt_nx   = '0;
                ck_nx    = 1'b0;
                load_div = 1'b1;
                // Wake has priority; a concurrent run is served afterwards.
                if (wake_req) begin
                    state_nx    = WAKE;
                    busy_nx     = 1'b1;
                    csn_nx      = 1'b1;
                    wake_cnt_nx = '0;
                    wake_sel    = 1'b1;
                end else if (run) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (run) begin
                    counting = 1'b1;
                end else if (sd_ck) begin
                    // Let the high phase run out before stopping.
                    counting = 1'b1;
                    state_nx = STOPPING;
                end else begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    load_div = 1'b1;
                end
            end
            STOPPING: begin
                counting = 1'b1;
            end
            WAKE: begin
                wake_sel = 1'b1;
                // The last fall has already happened; spend one cycle low
                // before releasing chip select and pulsing done.
                if (wake_cnt == WAKE_LAST) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    csn_nx   = 1'b0;
                    done_nx  = 1'b1;
                    cnt_nx   = '0;
                    load_div = 1'b1;
                end else begin
                    counting = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (counting) begin
            if (cnt == div_act) begin
                cnt_nx  = '0;
                ck_nx   = ~sd_ck;
                rise_nx = ~sd_ck;
                fall_nx = sd_ck;
                if (sd_ck) begin
                    load_div = 1'b1;
                    if (state_nx == STOPPING) begin
                        state_nx = IDLE;
                    end
                    if (state == WAKE) begin
                        wake_cnt_nx = wake_cnt + 1'b1;
                    end
                end
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end

        if (load_div) begin
            div_nx = (wake_sel || !fast_mode) ? INIT_V : FAST_V;
        end
        fast_nx = (div_nx == FAST_V);
    end

    // State and output registers; every output is a flop so sd_ck and the
    // strobes are glitch-free and change on the same clk edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_act     <= INIT_V;
            wake_cnt    <= '0;
            sd_ck       <= 1'b0;
            rise_stb    <= 1'b0;
            fall_stb    <= 1'b0;
            wake_busy   <= 1'b0;
            wake_done   <= 1'b0;
            csn_hold    <= 1'b0;
            fast_active <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            div_act     <= div_nx;
            wake_cnt    <= wake_cnt_nx;
            sd_ck       <= ck_nx;
            rise_stb    <= rise_nx;
            fall_stb    <= fall_nx;
            wake_busy   <= busy_nx;
            wake_done   <= done_nx;
            csn_hold    <= csn_nx;
            fast_active <= fast_nx;
        end
    end

endmodule : sd_clk_gen

// File: tb/tb_sd_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_sd_clk_gen
// Self-checking bench for sd_clk_gen: a short table of per-cycle vectors,
// hand-written multi-cycle sequences, and a randomized run compared every
// cycle against a countdown-based reference model.
// ---------------------------------------------------------------------------
module tb_sd_clk_gen;

    localparam int INIT  = 62;
    localparam int FAST  = 0;
    localparam int WCYC  = 80;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_WAKE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic fast_mode = 1'b0;
    logic wake_req = 1'b0;
    logic wake_busy, wake_done, csn_hold, sd_ck, rise_stb, fall_stb, fast_active;
    logic [6:0] dutVec;

    int checks = 0;
    int errors = 0;

    // Reference model: phase lengths and cycles left in the current phase.
    int mState = M_IDLE;
    int mHalf  = INIT + 1;
    int mLeft  = 0;
    int mFalls = 0;
    bit mCk = 0, mRise = 0, mFall = 0, mBusy = 0, mDone = 0, mCsn = 0, mFast = 0;

    typedef struct {
        bit         rst;
        bit         run;
        bit         fast;
        bit         wake;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[11];

    sd_clk_gen #(
        .DIV_W       (8),
        .INIT_DIV    (INIT),
        .FAST_DIV    (FAST),
        .WAKE_CYCLES (WCYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .fast_mode   (fast_mode),
        .wake_req    (wake_req),
        .wake_busy   (wake_busy),
        .wake_done   (wake_done),
        .csn_hold    (csn_hold),
        .sd_ck       (sd_ck),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .fast_active (fast_active)
    );

    assign dutVec = {sd_ck, rise_stb, fall_stb, wake_busy, wake_done, csn_hold, fast_active};

    always #5 clk = ~clk;

    function automatic int selHalf(input bit inWake);
        return (inWake || !fast_mode) ? INIT + 1 : FAST + 1;
    endfunction

    function automatic logic [6:0] modelVec();
        return {mCk, mRise, mFall, mBusy, mDone, mCsn, mFast};
    endfunction

    task automatic modelStep();
        bit advance;
        advance = 0;
        mRise = 0;
        mFall = 0;
        mDone = 0;
        if (rst) begin
            mState = M_IDLE;
            mCk    = 0;
            mBusy  = 0;
            mCsn   = 0;
            mHalf  = INIT + 1;
            mLeft  = 0;
            mFalls = 0;
            mFast  = 0;
            return;
        end
        case (mState)
            M_IDLE: begin
                if (wake_req) begin
                    mState = M_WAKE;
                    mBusy  = 1;
                    mCsn   = 1;
                    mFalls = 0;
                    mHalf  = INIT + 1;
                    mLeft  = mHalf;
                end else begin
                    mHalf = selHalf(0);
                    mLeft = mHalf;
                    if (run) mState = M_RUN;
                end
            end
            M_RUN: begin
                if (run) begin
                    advance = 1;
                end else if (mCk) begin
                    mState  = M_STOP;
                    advance = 1;
                end else begin
                    mState = M_IDLE;
                    mHalf  = selHalf(0);
                end
            end
            M_STOP: advance = 1;
            default: begin
                if (mFalls == WCYC) begin
                    mState = M_IDLE;
                    mBusy  = 0;
                    mCsn   = 0;
                    mDone  = 1;
                    mHalf  = INIT + 1;
                end else begin
                    advance = 1;
                end
            end
        endcase
        if (advance) begin
            mLeft--;
            if (mLeft == 0) begin
                mCk = !mCk;
                if (mCk) begin
                    mRise = 1;
                end else begin
                    mFall = 1;
                    mHalf = selHalf(mState == M_WAKE);
                    if (mState == M_STOP) mState = M_IDLE;
                    if (mState == M_WAKE) mFalls++;
                end
                mLeft = mHalf;
            end
        end
        mFast = (mHalf == FAST + 1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clk cycle: model follows the edge, outputs compared at the negedge.
    task automatic cycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("model", 32'(dutVec), 32'(modelVec()));
    endtask

    task automatic applyStimulus(input bit r, input bit rn, input bit fm, input bit wr);
        rst       = r;
        run       = rn;
        fast_mode = fm;
        wake_req  = wr;
        cycle();
    endtask

    task automatic waitRise(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (rise_stb) begin
                ok = 1;
                break;
            end
            cycle();
        end
        if (!ok) checkOutput("waitRise timeout", 32'(0), 32'(1));
    endtask

    task automatic measurePhase(output int len);
        logic lvl;
        lvl = sd_ck;
        len = 1;
        for (int i = 0; i < 500; i++) begin
            cycle();
            if (sd_ck == lvl) len++;
            else break;
        end
    endtask

    task automatic runBurst(output int rises, output int gap, output int csnBad, output bit done,
                            input int extraReqAt);
        int lastFall;
        rises    = 0;
        gap      = -1;
        csnBad   = 0;
        done     = 0;
        lastFall = -100;
        for (int t = 0; t < 12000; t++) begin
            wake_req = (t == extraReqAt);
            cycle();
            if (rise_stb) rises++;
            if (wake_busy && !csn_hold) csnBad++;
            if (fall_stb) lastFall = t;
            if (wake_done) begin
                gap  = t - lastFall;
                done = 1;
                break;
            end
        end
        wake_req = 0;
    endtask

    initial begin
        int len, rises, gap, csnBad, cnt;
        bit done;

        // {sd_ck, rise, fall, busy, done, csn, fast_active} after each edge
        vecs[0]  = '{1, 0, 0, 0, 7'b0000000};
        vecs[1]  = '{0, 1, 1, 0, 7'b0000001};
        vecs[2]  = '{0, 1, 1, 0, 7'b1100001};
        vecs[3]  = '{0, 1, 1, 0, 7'b0010001};
        vecs[4]  = '{0, 1, 1, 0, 7'b1100001};
        vecs[5]  = '{0, 0, 1, 0, 7'b0010001};
        vecs[6]  = '{0, 0, 1, 0, 7'b0000001};
        vecs[7]  = '{0, 0, 0, 0, 7'b0000000};
        vecs[8]  = '{0, 0, 1, 1, 7'b0001010};
        vecs[9]  = '{0, 0, 1, 0, 7'b0001010};
        vecs[10] = '{1, 0, 1, 0, 7'b0000000};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].fast, vecs[i].wake);
            checkOutput($sformatf("vec[%0d]", i), 32'(dutVec), 32'(vecs[i].exp));
        end

        // Slow mode: 8 rising edges in 1000 cycles, 63-cycle phases.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        rises = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (rise_stb) rises++;
        end
        checkOutput("slow rises in 1000", 32'(rises), 32'(8));
        waitRise(300);
        measurePhase(len);
        checkOutput("slow high phase", 32'(len), 32'(INIT + 1));
        measurePhase(len);
        checkOutput("slow low phase", 32'(len), 32'(INIT + 1));

        // Mode switch mid high phase: high keeps 63, following low is 1.
        waitRise(300);
        len = 1;
        for (int i = 0; i < 200; i++) begin
            if (len == 30) fast_mode = 1;
            cycle();
            if (sd_ck) len++;
            else break;
        end
        checkOutput("switch high phase", 32'(len), 32'(INIT + 1));
        measurePhase(len);
        checkOutput("switch low phase", 32'(len), 32'(FAST + 1));
        measurePhase(len);
        checkOutput("fast high phase", 32'(len), 32'(FAST + 1));
        checkOutput("fast_active after switch", 32'(fast_active), 32'(1));

        // Drop run 10 cycles into a slow high phase.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        waitRise(300);
        len = 1;
        for (int i = 0; i < 200; i++) begin
            if (len == 10) run = 0;
            cycle();
            if (sd_ck) len++;
            else break;
        end
        checkOutput("stop high phase", 32'(len), 32'(INIT + 1));
        checkOutput("stop fall_stb", 32'(fall_stb), 32'(1));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (sd_ck) cnt++;
        end
        checkOutput("stays low after stop", 32'(cnt), 32'(0));

        // Wake burst in fast mode with an ignored mid-burst request.
        applyStimulus(1, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("busy after wake_req", 32'(wake_busy), 32'(1));
        checkOutput("csn after wake_req", 32'(csn_hold), 32'(1));
        runBurst(rises, gap, csnBad, done, 5000);
        checkOutput("wake done seen", 32'(done), 32'(1));
        checkOutput("wake rises", 32'(rises), 32'(WCYC));
        checkOutput("wake_done after last fall", 32'(gap), 32'(1));
        checkOutput("csn during burst", 32'(csnBad), 32'(0));
        checkOutput("busy at done", 32'(wake_busy), 32'(0));
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (wake_busy) cnt++;
        end
        checkOutput("no queued wake", 32'(cnt), 32'(0));

        // Reset in the middle of a burst.
        applyStimulus(1, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        wake_req = 0;
        rises = 0;
        for (int i = 0; i < 6000; i++) begin
            cycle();
            if (rise_stb) rises++;
            if (rises == 40) break;
        end
        checkOutput("reached wake edge 40", 32'(rises), 32'(40));
        applyStimulus(1, 0, 1, 0);
        checkOutput("outputs after mid-wake reset", 32'(dutVec), 32'(0));
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (wake_done || wake_busy) cnt++;
        end
        checkOutput("no done after reset", 32'(cnt), 32'(0));
        applyStimulus(0, 0, 1, 1);
        runBurst(rises, gap, csnBad, done, -1);
        checkOutput("fresh wake rises", 32'(rises), 32'(WCYC));
        checkOutput("fresh wake done", 32'(done), 32'(1));

        // Randomized traffic against the reference model.
        applyStimulus(1, 0, 0, 0);
        rst = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 199) == 0) run = ~run;
            if ($urandom_range(0, 149) == 0) fast_mode = ~fast_mode;
            wake_req = ($urandom_range(0, 1499) == 0);
            rst      = ($urandom_range(0, 4999) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sd_clk_gen
